// File: rtl/branch_predictor_gshare.sv
// Gshare branch predictor: direct-mapped BTB plus 2-bit counter PHT indexed by PC xor GHR.
// Tables are cleared by a one-entry-per-cycle INIT sweep; lookups are registered one cycle.
module branch_predictor_gshare #(
  parameter int ADDR_WIDTH = 26,
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
  output logic                  o_valid,
  output logic                  o_prediction,
  output logic [ADDR_WIDTH-1:0] o_target,
  input  logic                  i_update_en,
  input  logic [ADDR_WIDTH-1:0] i_update_pc,
  input  logic                  i_update_taken,
  input  logic [ADDR_WIDTH-1:0] i_update_target,
  output logic                  o_init_done
);
  localparam int TAG_BITS = ADDR_WIDTH - 2 - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   init_cnt_q, init_cnt_d;
  logic [GHR_BITS-1:0]     ghr_q, ghr_d;
  logic                    valid_q, valid_d;
  logic                    pred_q, pred_d;
  logic [ADDR_WIDTH-1:0]   target_q, target_d;
  logic                    init_done_q, init_done_d;

  logic                    btb_valid  [ENTRIES];
  logic [TAG_BITS-1:0]     btb_tag    [ENTRIES];
  logic [ADDR_WIDTH-1:0]   btb_target [ENTRIES];
  logic [1:0]              pht        [ENTRIES];

  logic [INDEX_BITS-1:0]   lk_idx, lk_pht_idx, up_idx, up_pht_idx;
  logic [TAG_BITS-1:0]     lk_tag, up_tag;
  logic                    run, upd_en;
  logic                    unused_pc_bits;

  function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

  assign lk_idx         = i_lookup_pc[INDEX_BITS+1:2];
  assign lk_tag         = i_lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign lk_pht_idx     = lk_idx ^ INDEX_BITS'(ghr_q);
  assign up_idx         = i_update_pc[INDEX_BITS+1:2];
  assign up_tag         = i_update_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign up_pht_idx     = up_idx ^ INDEX_BITS'(ghr_q);
  assign run            = (state_q == ST_RUN);
  assign upd_en         = rst_n & run & i_update_en;
  assign unused_pc_bits = ^{i_lookup_pc[1:0], i_update_pc[1:0]};

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ghr_d      = ghr_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) state_d = ST_RUN;
      end
      default: begin
        if (i_update_en) ghr_d = {ghr_q[GHR_BITS-2:0], i_update_taken};
      end
    endcase
    // Lookup reads pre-update table contents; no same-cycle bypass.
    valid_d     = run & btb_valid[lk_idx] & (btb_tag[lk_idx] == lk_tag);
    pred_d      = valid_d & pht[lk_pht_idx][1];
    target_d    = run ? btb_target[lk_idx] : '0;
    init_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      ghr_q       <= '0;
      valid_q     <= 1'b0;
      pred_q      <= 1'b0;
      target_q    <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ghr_q       <= ghr_d;
      valid_q     <= valid_d;
      pred_q      <= pred_d;
      target_q    <= target_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      btb_valid[init_cnt_q] <= 1'b0;
      pht[init_cnt_q]       <= 2'b01;
    end else if (upd_en) begin
      pht[up_pht_idx] <= pht_next(pht[up_pht_idx], i_update_taken);
      if (i_update_taken) begin
        btb_valid[up_idx]  <= 1'b1;
        btb_tag[up_idx]    <= up_tag;
        btb_target[up_idx] <= i_update_target;
      end
    end
  end

  assign o_valid      = valid_q;
  assign o_prediction = pred_q;
  assign o_target     = target_q;
  assign o_init_done  = init_done_q;
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare: expected lookup results are queued when a
// lookup is driven and popped when the registered result appears one cycle later.
module tb_branch_predictor_gshare;
  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] i_lookup_pc;
  logic          o_valid, o_prediction, o_init_done;
  logic [AW-1:0] o_target;
  logic          i_update_en, i_update_taken;
  logic [AW-1:0] i_update_pc, i_update_target;

  always #5 clk = ~clk;

  branch_predictor_gshare dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_lookup_pc    (i_lookup_pc),
    .o_valid        (o_valid),
    .o_prediction   (o_prediction),
    .o_target       (o_target),
    .i_update_en    (i_update_en),
    .i_update_pc    (i_update_pc),
    .i_update_taken (i_update_taken),
    .i_update_target(i_update_target),
    .o_init_done    (o_init_done)
  );

  typedef struct {
    string         tag;
    logic          v;
    logic          p;
    logic [AW-1:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit lk, input logic [AW-1:0] lpc, input string tag,
                       input logic ev, input logic ep, input logic [AW-1:0] et,
                       input bit up, input logic [AW-1:0] upc, input logic utk,
                       input logic [AW-1:0] utgt);
    exp_t e;
    @(negedge clk);
    i_lookup_pc     = lpc;
    i_update_en     = up;
    i_update_pc     = upc;
    i_update_taken  = utk;
    i_update_target = utgt;
    if (lk) begin
      e.tag = tag; e.v = ev; e.p = ep; e.t = et;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    i_update_en = 1'b0;
    if (lk) begin
      if (exp_q.size() == 0) begin
        check({tag, ".queue"}, AW'(0), AW'(1));
      end else begin
        e = exp_q.pop_front();
        check({e.tag, ".valid"}, AW'(o_valid), AW'(e.v));
        check({e.tag, ".pred"},  AW'(o_prediction), AW'(e.p));
        if (e.v) check({e.tag, ".target"}, o_target, e.t);
      end
    end
  endtask

  task automatic lookup(input logic [AW-1:0] pc, input string tag, input logic ev,
                        input logic ep, input logic [AW-1:0] et);
    cycle(1'b1, pc, tag, ev, ep, et, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic update(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tgt);
    cycle(1'b0, '0, "", 1'b0, 1'b0, '0, 1'b1, pc, tk, tgt);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".valid"},     AW'(o_valid), '0);
    check({tag, ".pred"},      AW'(o_prediction), '0);
    check({tag, ".target"},    o_target, '0);
    check({tag, ".init_done"}, AW'(o_init_done), '0);
  endtask

  // Releases reset and walks the 64-cycle INIT sweep, optionally offering updates throughout.
  task automatic init_wait(input bit upd_during);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      i_lookup_pc     = 26'h040;
      i_update_en     = upd_during;
      i_update_pc     = 26'h040;
      i_update_taken  = 1'b1;
      i_update_target = 26'h100;
      @(posedge clk); #1;
      check($sformatf("init_done[%0d]", i), AW'(o_init_done), AW'(i == 63));
      check($sformatf("init_valid[%0d]", i), AW'(o_valid), '0);
    end
    i_update_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_lookup_pc = '0; i_update_en = 1'b0; i_update_pc = '0;
    i_update_taken = 1'b0; i_update_target = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");

    init_wait(1'b0);

    lookup(26'h040, "t2_cold", 1'b0, 1'b0, '0);

    update(26'h040, 1'b1, 26'h100);
    lookup(26'h040, "t3_train", 1'b1, 1'b0, 26'h100);
    lookup(26'h140, "t5_alias_miss", 1'b0, 1'b0, '0);

    repeat (6) update(26'h080, 1'b1, 26'h180);
    repeat (4) update(26'h040, 1'b1, 26'h100);
    lookup(26'h040, "t4_sat_high", 1'b1, 1'b1, 26'h100);

    update(26'h140, 1'b1, 26'h200);
    lookup(26'h040, "t5_evicted", 1'b0, 1'b0, '0);
    lookup(26'h140, "t5_alias_hit", 1'b1, 1'b1, 26'h200);

    // Two not-taken updates land on PHT[0x1C]; the counter must floor at 0.
    update(26'h08C, 1'b0, '0);
    update(26'h088, 1'b0, '0);
    lookup(26'h080, "sat_low", 1'b1, 1'b0, 26'h180);

    cycle(1'b1, 26'h040, "t6_collide", 1'b0, 1'b0, '0, 1'b1, 26'h040, 1'b1, 26'h100);
    lookup(26'h040, "t6_after", 1'b1, 1'b0, 26'h100);

    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    reset_checks("mid_reset");
    @(posedge clk); #1;

    init_wait(1'b1);
    lookup(26'h040, "t6_post_reset", 1'b0, 1'b0, '0);
    lookup(26'h080, "post_reset_080", 1'b0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
